// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds,
// an occupancy count, and registered overflow/underflow error pulses.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AF_THRESH = 2**ADDR_W - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DepthC = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AfC    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AeC    = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q;
  logic              overflow_q, underflow_q;
  logic              do_wr, do_rd;

  // Flags decode from the count register only, never from wr/rd.
  always_comb begin
    full         = (count_q == DepthC);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfC);
    almost_empty = (count_q <= AeC);
  end

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= wr && full;
      underflow_q <= rd && empty;
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) begin
        rptr_q <= rptr_q + 1'b1;
        dout_q <= mem[rptr_q];
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= din;
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at default parameters.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo_param dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .rd           (rd),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    step();
    rst = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1;
      din = 8'(i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
      chk("fill_full", 32'(full), 32'(i + 1 == 16));
      chk("fill_ovf", 32'(overflow), 32'd0);
    end

    // Overflow
    din = 8'hAA;
    step();
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    wr = 1'b0;
    step();
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Drain
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_dout", 32'(dout), 32'(i));
      chk("drain_count", 32'(count), 32'(15 - i));
      chk("drain_ae", 32'(almost_empty), 32'(15 - i <= 2));
    end
    rd = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    step();
    chk("rd_empty_udf", 32'(underflow), 32'd0);

    // Single word across the pointer wrap
    wr = 1'b1;
    din = 8'h55;
    step();
    wr = 1'b0;
    chk("wrap_count", 32'(count), 32'd1);
    chk("wrap_nempty", 32'(empty), 32'd0);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("wrap_dout", 32'(dout), 32'h55);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Preload 5 words then stream with concurrent rd/wr
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'(8'h10 + i);
      step();
    end
    chk("pre_count", 32'(count), 32'd5);
    rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 8'(8'h15 + i);
      step();
      chk("sim_count", 32'(count), 32'd5);
      chk("sim_dout", 32'(dout), 32'(8'h10 + i));
    end
    wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("tail_dout", 32'(dout), 32'(8'h24 + i));
    end
    rd = 1'b0;
    chk("tail_empty", 32'(empty), 32'd1);

    // Empty with rd=wr=1
    rd = 1'b1;
    wr = 1'b1;
    din = 8'h77;
    step();
    rd = 1'b0;
    wr = 1'b0;
    chk("be_count", 32'(count), 32'd1);
    chk("be_udf", 32'(underflow), 32'd1);
    chk("be_dout_hold", 32'(dout), 32'h28);
    step();
    chk("be_udf_clear", 32'(underflow), 32'd0);

    // Fill to full, then rd=wr=1
    wr = 1'b1;
    for (int i = 0; i < 15; i++) begin
      din = 8'(8'h80 + i);
      step();
    end
    chk("bf_full", 32'(full), 32'd1);
    rd = 1'b1;
    din = 8'hEE;
    step();
    rd = 1'b0;
    wr = 1'b0;
    chk("bf_count", 32'(count), 32'd15);
    chk("bf_ovf", 32'(overflow), 32'd1);
    chk("bf_dout", 32'(dout), 32'h77);

    // Down to 7 entries, then asynchronous reset between edges
    rd = 1'b1;
    for (int i = 0; i < 8; i++) step();
    rd = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd7);
    chk("pre_rst_dout", 32'(dout), 32'h87);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_dout", 32'(dout), 32'd0);
    step();
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
